// File: rtl/seq_serializer.sv
// Parallel-in, serial-out stage with a one-word pending buffer.
// It feeds the 10110 sequence detector with gap-free bit streams.
module seq_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter logic        IDLE_LEVEL = 1'b0,
  parameter int unsigned CNT_W      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_msb_first,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic               msb_q, msb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   pend_data_q, pend_data_d;
  logic               pend_msb_q, pend_msb_d;
  logic               pend_valid_q, pend_valid_d;
  logic               ser_out_q, ser_out_d;
  logic               ser_valid_q, ser_valid_d;
  logic               word_done_q, word_done_d;
  logic               busy_q, busy_d;

  logic               accept;
  logic               last_bit;
  logic               can_load;
  logic               do_load;
  logic [WIDTH-1:0]   load_data;
  logic               load_msb;

  assign in_ready  = !pend_valid_q;
  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign word_done = word_done_q;
  assign busy      = busy_q;

  // Next-state: load selection, pending buffer and bit shifting
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    msb_d        = msb_q;
    cnt_d        = cnt_q;
    pend_data_d  = pend_data_q;
    pend_msb_d   = pend_msb_q;
    pend_valid_d = pend_valid_q;
    ser_out_d    = ser_out_q;
    ser_valid_d  = ser_valid_q;
    word_done_d  = word_done_q;
    do_load      = 1'b0;
    load_data    = in_data;
    load_msb     = in_msb_first;

    accept   = in_valid && !pend_valid_q;
    last_bit = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);
    can_load = (state_q == ST_IDLE) || last_bit;

    // Pending word wins; otherwise a fresh word bypasses the buffer
    if (can_load) begin
      if (pend_valid_q) begin
        do_load      = 1'b1;
        load_data    = pend_data_q;
        load_msb     = pend_msb_q;
        pend_valid_d = 1'b0;
      end else if (accept) begin
        do_load = 1'b1;
      end
    end else if (accept) begin
      pend_data_d  = in_data;
      pend_msb_d   = in_msb_first;
      pend_valid_d = 1'b1;
    end

    if (do_load) begin
      state_d     = ST_SHIFT;
      cnt_d       = '0;
      msb_d       = load_msb;
      ser_valid_d = 1'b1;
      word_done_d = 1'b0;
      ser_out_d   = load_msb ? load_data[WIDTH-1] : load_data[0];
      shreg_d     = load_msb ? (load_data << 1) : (load_data >> 1);
    end else if ((state_q == ST_SHIFT) && !last_bit) begin
      cnt_d       = cnt_q + CNT_W'(1);
      ser_out_d   = msb_q ? shreg_q[WIDTH-1] : shreg_q[0];
      shreg_d     = msb_q ? (shreg_q << 1) : (shreg_q >> 1);
      word_done_d = ((cnt_q + CNT_W'(1)) == LAST_CNT);
    end else begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      shreg_d     = '0;
      ser_valid_d = 1'b0;
      ser_out_d   = IDLE_LEVEL;
      word_done_d = 1'b0;
    end

    busy_d = (state_d == ST_SHIFT) || pend_valid_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      msb_q        <= 1'b0;
      cnt_q        <= '0;
      pend_data_q  <= '0;
      pend_msb_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      ser_out_q    <= IDLE_LEVEL;
      ser_valid_q  <= 1'b0;
      word_done_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      msb_q        <= msb_d;
      cnt_q        <= cnt_d;
      pend_data_q  <= pend_data_d;
      pend_msb_q   <= pend_msb_d;
      pend_valid_q <= pend_valid_d;
      ser_out_q    <= ser_out_d;
      ser_valid_q  <= ser_valid_d;
      word_done_q  <= word_done_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Randomized and directed bench for seq_serializer (WIDTH=5) against a
// timeline model: each accepted word owns a start cycle and WIDTH bit slots.
module tb_seq_serializer;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_msb_first = 1'b1;
  logic         in_ready;
  logic         ser_out;
  logic         ser_valid;
  logic         word_done;
  logic         busy;

  seq_serializer #(.WIDTH(W), .IDLE_LEVEL(1'b0)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_msb_first (in_msb_first),
    .in_ready     (in_ready),
    .ser_out      (ser_out),
    .ser_valid    (ser_valid),
    .word_done    (word_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic acc_now = 1'b0;
  logic [4:0] exp_v;
  logic [4:0] got_v;

  // Accepted words: data, order flag, accept edge, first-bit cycle
  logic [W-1:0] w_data[$];
  logic         w_msb[$];
  int           w_e[$];
  int           w_s[$];

  // Expected {ser_valid, ser_out, word_done, busy, in_ready} in cycle c
  function automatic logic [4:0] model_out(input int c);
    logic v, b, d, p;
    logic [W-1:0] t;
    int k;
    v = 1'b0; b = 1'b0; d = 1'b0; p = 1'b0;
    for (int i = 0; i < w_s.size(); i++) begin
      if (c >= w_s[i] && c < w_s[i] + W) begin
        v = 1'b1;
        k = c - w_s[i];
        t = w_msb[i] ? (w_data[i] >> (W - 1 - k)) : (w_data[i] >> k);
        b = t[0];
        d = (k == W - 1);
      end
      if (c >= w_e[i] && c < w_s[i]) p = 1'b1;
    end
    return {v, b, d, v | p, ~p};
  endfunction

  task automatic model_clear();
    w_data.delete(); w_msb.delete(); w_e.delete(); w_s.delete();
  endtask

  // One clock: update the model with the handshake at this edge, then settle
  task automatic tick();
    logic [4:0] pre;
    int s;
    @(posedge clk);
    pre = model_out(cyc);
    cyc++;
    acc_now = in_valid && pre[0];
    if (acc_now) begin
      s = cyc;
      if (w_s.size() > 0 && w_s[w_s.size()-1] + W > cyc) s = w_s[w_s.size()-1] + W;
      w_data.push_back(in_data);
      w_msb.push_back(in_msb_first);
      w_e.push_back(cyc);
      w_s.push_back(s);
    end
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    got_v = {ser_valid, ser_out, word_done, busy, in_ready};
    total++;
    if (got_v !== 5'b00001) begin
      bad++;
      $display("FAIL reset_state got=%b exp=%b", got_v, 5'b00001);
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    model_clear();
  endtask

  task automatic test_idle();
    for (int n = 0; n < 20; n++) begin
      tick();
      got_v = {ser_valid, ser_out, word_done, busy, in_ready};
      total++;
      if (got_v !== 5'b00001) begin
        bad++;
        $display("FAIL idle_line cyc=%0d got=%b exp=%b", cyc, got_v, 5'b00001);
      end
    end
  endtask

  task automatic run_single(input logic [W-1:0] d, input logic m, input string nm);
    logic [W-1:0] col;
    int nval, done_at;
    col = '0; nval = 0; done_at = -1;
    in_data = d; in_msb_first = m; in_valid = 1'b1;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (acc_now) in_valid = 1'b0;
      exp_v = model_out(cyc);
      got_v = {ser_valid, ser_out, word_done, busy, in_ready};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, got_v, exp_v);
      end
      if (ser_valid === 1'b1) begin
        col = {col[W-2:0], ser_out};
        nval++;
        if (word_done === 1'b1) done_at = nval;
      end
    end
    total++;
    if (col !== 5'b10110 || nval != 5 || done_at != 5) begin
      bad++;
      $display("FAIL %s_stream bits=%b nvalid=%0d done_at=%0d exp bits=10110 nvalid=5 done_at=5",
               nm, col, nval, done_at);
    end
  endtask

  task automatic test_bit_order();
    run_single(5'b10110, 1'b1, "msb_first");
    run_single(5'b01101, 1'b0, "lsb_first");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words[2];
    logic [9:0] col, dn;
    int idx, nval, first, last;
    words[0] = 5'b10110; words[1] = 5'b11011;
    col = '0; dn = '0; idx = 0; nval = 0; first = -1; last = -1;
    in_msb_first = 1'b1;
    for (int n = 0; n < 16; n++) begin
      in_valid = (idx < 2);
      in_data  = words[idx < 2 ? idx : 1];
      tick();
      if (acc_now) idx++;
      exp_v = model_out(cyc);
      got_v = {ser_valid, ser_out, word_done, busy, in_ready};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL back_to_back cyc=%0d got=%b exp=%b", cyc, got_v, exp_v);
      end
      if (ser_valid === 1'b1) begin
        col = {col[8:0], ser_out};
        dn  = {dn[8:0], word_done};
        nval++;
        if (first < 0) first = cyc;
        last = cyc;
      end
    end
    in_valid = 1'b0;
    total++;
    if (col !== 10'b1011011011 || dn !== 10'b0000100001 || nval != 10 || last - first != 9) begin
      bad++;
      $display("FAIL b2b_stream bits=%b done=%b nvalid=%0d span=%0d exp 1011011011 0000100001 10 10",
               col, dn, nval, last - first + 1);
    end
  endtask

  task automatic test_four_held();
    logic [W-1:0] words[4];
    logic [19:0] col, want;
    int idx, nval;
    logic saw_stall;
    words[0] = 5'b10110; words[1] = 5'b01001; words[2] = 5'b11100; words[3] = 5'b00111;
    want = {words[0], words[1], words[2], words[3]};
    col = '0; idx = 0; nval = 0; saw_stall = 1'b0;
    in_msb_first = 1'b1;
    for (int n = 0; n < 30; n++) begin
      in_valid = (idx < 4);
      in_data  = words[idx < 4 ? idx : 3];
      tick();
      if (acc_now) idx++;
      exp_v = model_out(cyc);
      got_v = {ser_valid, ser_out, word_done, busy, in_ready};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL four_held cyc=%0d got=%b exp=%b", cyc, got_v, exp_v);
      end
      if (in_ready === 1'b0) saw_stall = 1'b1;
      if (ser_valid === 1'b1) begin
        col = {col[18:0], ser_out};
        nval++;
      end
    end
    in_valid = 1'b0;
    total++;
    if (col !== want || nval != 20 || saw_stall !== 1'b1) begin
      bad++;
      $display("FAIL four_stream bits=%b nvalid=%0d stall=%b exp bits=%b nvalid=20 stall=1",
               col, nval, saw_stall, want);
    end
  endtask

  task automatic test_reset_mid();
    int s;
    s = -100;
    in_data = 5'b10110; in_msb_first = 1'b1; in_valid = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (acc_now) begin
        in_valid = 1'b0;
        s = cyc;
      end
      exp_v = model_out(cyc);
      got_v = {ser_valid, ser_out, word_done, busy, in_ready};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL reset_mid_pre cyc=%0d got=%b exp=%b", cyc, got_v, exp_v);
      end
      if (cyc == s + 2) break;
    end
    total++;
    if (cyc != s + 2) begin
      bad++;
      $display("FAIL reset_mid_timeout cyc=%0d exp=%0d", cyc, s + 2);
    end
    #3 rst = 1'b0;
    #1;
    got_v = {ser_valid, ser_out, word_done, busy, in_ready};
    total++;
    if (got_v !== 5'b00001) begin
      bad++;
      $display("FAIL reset_mid_async got=%b exp=%b", got_v, 5'b00001);
    end
    model_clear();
    #1 rst = 1'b1;
    for (int n = 0; n < 8; n++) begin
      tick();
      got_v = {ser_valid, ser_out, word_done, busy, in_ready};
      total++;
      if (got_v !== 5'b00001) begin
        bad++;
        $display("FAIL reset_mid_after cyc=%0d got=%b exp=%b", cyc, got_v, 5'b00001);
      end
    end
  endtask

  task automatic test_random();
    in_valid = 1'b0;
    acc_now  = 1'b0;
    for (int n = 0; n < 440; n++) begin
      if (!in_valid || acc_now) begin
        in_valid     = (n < 400) && ($urandom_range(0, 9) < 7);
        in_data      = W'($urandom);
        in_msb_first = 1'($urandom);
      end
      tick();
      exp_v = model_out(cyc);
      got_v = {ser_valid, ser_out, word_done, busy, in_ready};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL random cyc=%0d got=%b exp=%b", cyc, got_v, exp_v);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_bit_order();
    test_back_to_back();
    test_four_held();
    test_reset_mid();
    do_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
- Parallel-in, serial-out stage that sits directly upstream of the 10110 sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on ser_out; ser_out drives the detector's in_seq.
- A one-word pending buffer lets consecutive words stream with no idle bits between them.
- When no word is in flight, ser_out holds IDLE_LEVEL so the detector sees a quiet, non-matching line.

Parameters:
- WIDTH, 8, bits per word; must be 2 or more.
- IDLE_LEVEL, 0, value driven on ser_out while no bit is valid.
- CNT_W, $clog2(WIDTH), width of the bit counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-low
- in_data  input  WIDTH  parallel word to send
- in_valid  input  1  in_data is valid
- in_msb_first  input  1  1 = send MSB first, 0 = send LSB first; captured together with the word
- in_ready  output  1  stage can accept a word this cycle
- ser_out  output  1  serial bit, connects to detector in_seq
- ser_valid  output  1  ser_out carries a word bit this cycle
- word_done  output  1  one-cycle pulse while the last bit of a word is on ser_out
- busy  output  1  shifter or pending buffer is occupied

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, shift register and pending buffer cleared.
  - pend_valid=0, ser_out=IDLE_LEVEL, ser_valid=0, word_done=0, busy=0.
  - in_ready=1 while in reset and after release.
- Handshake:
  - in_ready = !pend_valid (combinational from a register).
  - A word is accepted on a rising edge where in_valid && in_ready; in_msb_first is captured with it.
  - in_data must stay stable while in_valid is high and in_ready is low.
- States:
  - IDLE: shifter empty.
  - SHIFT: a word is being shifted; bit counter cnt runs 0..WIDTH-1.
- Load rule, evaluated at each rising edge:
  - If the shifter is in IDLE, or is presenting its last bit (cnt==WIDTH-1), it loads the next word.
  - The pending word has priority over the incoming word. If the pending buffer is empty, a word accepted at the same edge loads straight into the shifter.
  - A word accepted while the shifter stays busy goes into the pending buffer, and pend_valid is set.
- Latency: a word accepted at edge E into an idle shifter has its first bit on ser_out with ser_valid=1 in the cycle after E. Each following bit appears at each subsequent edge, for WIDTH consecutive cycles in total.
- Bit order: MSB first shifts left and outputs data[WIDTH-1]; LSB first shifts right and outputs data[0]. Order is fixed per word by the captured flag.
- All of ser_out, ser_valid and word_done are registered, with no combinational path from inputs.
- word_done=1 exactly in the cycle when cnt==WIDTH-1 and ser_valid=1.
- Back-to-back: if the next word is available at the last-bit edge, the new word's first bit follows the previous word's last bit with no gap, and ser_valid stays 1.
- End of stream: after the last bit, with nothing to load, the block returns to IDLE. ser_valid=0 and ser_out=IDLE_LEVEL from the next cycle.
- Last-bit edge with pending buffer full: the pending word moves to the shifter and pend_valid clears. in_ready was 0 that cycle, so nothing is accepted at that edge. in_ready=1 from the next cycle.
- busy = (state==SHIFT) || pend_valid.
- Reset mid-word: the word in flight and any pending word are discarded immediately, and outputs return to reset values asynchronously. No partial word resumes after reset release.

Test Plan:
- WIDTH=5, in_msb_first=1, send 5'b10110 once -> ser_out 1,0,1,1,0 on 5 consecutive cycles starting the cycle after the accept edge. ser_valid high for exactly those 5 cycles, word_done high only in the 5th, then ser_out=0 and ser_valid=0.
- WIDTH=5, in_msb_first=0, send 5'b01101 -> ser_out 1,0,1,1,0, identical to the previous scenario.
- WIDTH=5, back-to-back 5'b10110 then 5'b11011, both MSB first, in_valid held -> 10 contiguous valid bits 1011011011. word_done pulses at bits 5 and 10, no gap cycle between words.
- WIDTH=5, in_valid held high with 4 distinct words -> in_ready drops while the pending buffer is full. Every word appears exactly once and in order (20 bits); no loss and no duplication.
- Reset mid-word: drive rst low asynchronously, between clock edges, during bit 3 of 5'b10110 -> ser_valid=0, ser_out=0, busy=0 and in_ready=1 before the next edge. After release with no new input, ser_valid stays 0.
- Idle line: IDLE_LEVEL=0, no in_valid for 20 cycles after reset -> ser_out=0, ser_valid=0, word_done=0, busy=0 for all 20 cycles.
